// File: rtl/road_pkg.sv
// road_pkg: road-game geometry shared by the obstacle manager and collision checker,
// plus the collision checker state encoding.
package road_pkg;
    localparam int N_OBS = 6;
    localparam int X_W   = 8;
    localparam int Y_W   = 10;
    localparam int CAR_W = 16;
    localparam int CAR_H = 32;
    typedef enum logic [1:0] {IDLE, LATCH, SCAN, PENALTY} cc_state_t;
endpackage

// File: rtl/box_overlap.sv
// box_overlap: combinational bounding-box overlap of one obstacle slot against the player car.
module box_overlap
    import road_pkg::*;
#(
    parameter int CAR_W = road_pkg::CAR_W,
    parameter int CAR_H = road_pkg::CAR_H
) (
    input  logic           on,
    input  logic [X_W-1:0] px,
    input  logic [X_W-1:0] ox,
    input  logic [Y_W-1:0] py,
    input  logic [Y_W-1:0] oy,
    output logic           hit
);
    logic [X_W:0] px_e, ox_e;
    logic [Y_W:0] py_e, oy_e;
    // One extra bit so boxes near the right/bottom edge never wrap.
    assign px_e = {1'b0, px};
    assign ox_e = {1'b0, ox};
    assign py_e = {1'b0, py};
    assign oy_e = {1'b0, oy};
    assign hit = on
        && (px_e + (X_W+1)'(CAR_W) > ox_e) && (ox_e + (X_W+1)'(CAR_W) > px_e)
        && (py_e + (Y_W+1)'(CAR_H) > oy_e) && (oy_e + (Y_W+1)'(CAR_H) > py_e);
endmodule

// File: rtl/collision_checker.sv
// collision_checker: per-frame snapshot of the obstacle bus, sequential slot scan,
// crash pulse and frame-counted penalty.
module collision_checker
    import road_pkg::*;
#(
    parameter int N_OBS          = road_pkg::N_OBS,
    parameter int CAR_W          = road_pkg::CAR_W,
    parameter int CAR_H          = road_pkg::CAR_H,
    parameter int PENALTY_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 enable,
    input  logic [X_W-1:0]       player_x,
    input  logic [Y_W-1:0]       player_y,
    input  logic [N_OBS-1:0]     obstacle_on,
    input  logic [N_OBS*X_W-1:0] obstacle_x,
    input  logic [N_OBS*Y_W-1:0] obstacle_y,
    output logic                 crash,
    output logic                 crashing,
    output logic [2:0]           hit_index,
    output logic                 scan_busy,
    output logic [7:0]           crash_count
);
    cc_state_t                  state, state_nx;
    logic [X_W-1:0]             snap_px;
    logic [Y_W-1:0]             snap_py;
    logic [N_OBS-1:0]           snap_on;
    logic [N_OBS-1:0][X_W-1:0]  snap_ox;
    logic [N_OBS-1:0][Y_W-1:0]  snap_oy;
    logic [2:0]                 idx;
    logic [7:0]                 pen_cnt;
    logic                       hit, last_slot;

    assign last_slot = idx == 3'(N_OBS-1);
    assign crashing  = state == PENALTY;
    assign scan_busy = state == LATCH || state == SCAN;

    box_overlap #(.CAR_W(CAR_W), .CAR_H(CAR_H)) u_box (
        .on  (snap_on[idx]),
        .px  (snap_px),
        .ox  (snap_ox[idx]),
        .py  (snap_py),
        .oy  (snap_oy[idx]),
        .hit (hit)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_tick && enable ? LATCH : IDLE;
            LATCH:   state_nx = SCAN;
            SCAN:    state_nx = hit ? PENALTY : last_slot ? IDLE : SCAN;
            PENALTY: state_nx = frame_tick && pen_cnt == 8'd1 ? IDLE : PENALTY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_px     <= '0;
            snap_py     <= '0;
            snap_on     <= '0;
            snap_ox     <= '0;
            snap_oy     <= '0;
            idx         <= '0;
            pen_cnt     <= '0;
            crash       <= 1'b0;
            hit_index   <= '0;
            crash_count <= '0;
        end else begin
            crash <= state == SCAN && hit;
            if (state == LATCH) begin
                snap_px <= player_x;
                snap_py <= player_y;
                snap_on <= obstacle_on;
                snap_ox <= obstacle_x;
                snap_oy <= obstacle_y;
                idx     <= '0;
            end
            if (state == SCAN && hit) begin
                hit_index   <= idx;
                pen_cnt     <= 8'(PENALTY_FRAMES);
                crash_count <= crash_count + {7'd0, crash_count != 8'hff};
            end else if (state == SCAN) begin
                idx <= idx + 3'd1;
            end
            if (state == PENALTY && frame_tick) pen_cnt <= pen_cnt - 8'd1;
        end
    end
endmodule

// File: doc/collision_checker.md
# collision_checker

Downstream consumer of the obstacle manager's packed obstacle bus. Once per video frame it snapshots the six obstacle slots and the player car position, then scans the slots sequentially for a bounding-box overlap. On the first hit it emits a one-cycle `crash` pulse and holds a `crashing` penalty level for a fixed number of frames. The game FSM and player controller use `crashing` to freeze steering and speed.

## Interface
Parameters:
- `N_OBS`, 6: number of obstacle slots; must match the obstacle manager.
- `CAR_W`, 16: car width in pixels, used for both player and obstacle.
- `CAR_H`, 32: car height in pixels.
- `PENALTY_FRAMES`, 60: length of the crash penalty in frames; range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per frame, at vblank.
- `enable`  in  1  level; game running, allows new scans.
- `player_x`  in  8  player left edge.
- `player_y`  in  10  player top edge.
- `obstacle_on`  in  6  slot active flags.
- `obstacle_x`  in  48  slot i at bits [8i+7:8i].
- `obstacle_y`  in  60  slot i at bits [10i+9:10i].
- `crash`  out  1  one-cycle pulse on a detected hit.
- `crashing`  out  1  high for the whole penalty.
- `hit_index`  out  3  slot that caused the last crash.
- `scan_busy`  out  1  high while in LATCH or SCAN.
- `crash_count`  out  8  saturating count of crashes.

## Operation
- States: IDLE, LATCH, SCAN, PENALTY.
- IDLE, with `frame_tick`=1 and `enable`=1: go to LATCH. If `enable`=0, stay in IDLE.
- LATCH (1 cycle): register `player_x`/`player_y`, all of `obstacle_on`, `obstacle_x` and `obstacle_y`. Clear the index to 0. Go to SCAN.
- SCAN: one slot per cycle, index i from 0 to 5, using only the snapshot.
- Hit condition for slot i, all of:
  - `on[i]`=1;
  - `px + CAR_W > ox` and `ox + CAR_W > px`, computed 9 bits wide;
  - `py + CAR_H > oy` and `oy + CAR_H > py`, computed 11 bits wide.
  - There is no wrap-around at any edge.
- First hit in SCAN:
  - register `hit_index`=i;
  - pulse `crash`;
  - load the penalty counter with `PENALTY_FRAMES`;
  - increment `crash_count`, saturating at 255;
  - go to PENALTY. The remaining slots are not scanned.
- No hit by i=5: return to IDLE.
- PENALTY:
  - `crashing`=1.
  - Each `frame_tick` decrements the counter.
  - When the tick brings the counter to 0, go to IDLE. That tick does not start a scan.
  - `enable` is ignored while in PENALTY.
- A `frame_tick` arriving in LATCH or SCAN is ignored; it is not queued.
- Changes on the input buses after LATCH have no effect on the current scan.
- Reset mid-scan or mid-penalty: the FSM returns to IDLE immediately and all outputs take their reset values.

## Timing
- Reset values:
  - `crash`, `crashing`, `scan_busy` = 0;
  - `hit_index` = 0;
  - `crash_count` = 0;
  - state = IDLE;
  - snapshot registers = 0.
- Let `frame_tick` be sampled at edge T (state IDLE, `enable`=1):
  - state is LATCH after T and SCAN slot 0 after T+1;
  - slot i is evaluated in the cycle after edge T+1+i.
- Crash latency:
  - a hit on slot i is evaluated in the cycle after T+1+i;
  - `crash` is high in the cycle after edge T+2+i, for exactly 1 cycle;
  - `crashing` rises in the same cycle as `crash`;
  - `hit_index` and `crash_count` update in that same cycle;
  - worst case: `crash` in the cycle after T+7.
- `scan_busy` is high for at most 7 cycles: 1 LATCH cycle plus up to 6 SCAN cycles.
- `crashing` stays high through exactly `PENALTY_FRAMES` `frame_tick` pulses. It falls the cycle after the last of those ticks.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `road_pkg` holds:
  - `N_OBS`, `X_W`=8, `Y_W`=10;
  - `CAR_W`, `CAR_H`;
  - the state enum for this block.
- Sub-module `box_overlap` is combinational: one snapshot slot plus player position in, hit bit out. It is instantiated once and driven through a mux on the scan index.
- Top level contains the FSM, the snapshot registers, the penalty counter and the crash counter.

## Test plan
- No hit: player (100,400); slot 0 on at (150,100); others off; frame_tick -> scan completes, `crash` never asserts, `scan_busy` high 7 cycles.
- Overlap on slot 3: player (100,400), slot 3 on at (110,390) -> `crash` pulses exactly once in the cycle after T+5, `hit_index`=3, `crash_count`=1, `crashing`=1.
- Priority and inactive slots:
  - slots 1 and 4 both overlap -> `hit_index`=1;
  - an overlapping slot with `on`=0 -> no crash.
- Edge touch: player x=100, obstacle x=116, y equal -> no hit. Obstacle x=115 -> hit.
- Penalty: `PENALTY_FRAMES`=3, crash, then 3 ticks -> `crashing` falls after the 3rd tick. Ticks during the penalty cause no scans and no new `crash`, even with overlap still present.
- Reset and saturation:
  - reset asserted mid-SCAN -> all outputs 0 the same cycle, IDLE after release;
  - 256 crashes -> `crash_count` holds at 255.
